// File: rtl/output_line_step_sequencer.sv
// -----------------------------------------------------------------------------
// output_line_step_sequencer
//
// Walks a dense/conv layer as output rows x kernel steps x channel steps
// (channel step innermost) and issues one command per step over a
// valid/ready interface. Each command carries the AXI write address of the
// output line it belongs to. Output lines rotate through NUM_OUTPUT_LINES
// line buffers, and a row may only begin once a line credit is available.
//
// Optional feature macro: OUTPUT_SEQ_STRIDED_EN
//   defined   -> cfg_strided_i selects stride-2 row stepping
//   undefined -> cfg_strided_i is ignored (rows always step by 1)
//
// Ports:
//   clk_i               clock, rising edge
//   resetn_i            asynchronous active-low reset
//   start_i             one-cycle layer start, honoured only while idle
//   cfg_rows_i          number of input/output rows
//   cfg_kernel_steps_i  kernel steps per row
//   cfg_channel_steps_i channel steps per kernel step
//   cfg_kstep_bytes_i   address increment per kernel step
//   cfg_strided_i       stride-2 row mode
//   line_release_i      consumer returns one output-line credit
//   cmd_valid_o         command valid
//   cmd_ready_i         downstream accepts the command
//   cmd_row_o           input row index of the command
//   cmd_kernel_step_o   kernel step of the command
//   cmd_channel_step_o  channel step of the command
//   cmd_out_addr_o      output-line write address
//   cmd_last_channel_o  last channel step (writeback step)
//   cmd_last_o          final command of the layer
//   busy_o              sequencer not idle
//   done_o              one-cycle completion pulse
//   credit_err_o        sticky: a credit was returned while credits were full
// -----------------------------------------------------------------------------
module output_line_step_sequencer #(
    parameter int ADDR_W             = 32,
    parameter int STEP_W             = 16,
    parameter int ROW_W              = 12,
    parameter int NUM_OUTPUT_LINES   = 3,
    parameter int OUTPUT_LINE_BASE   = 6144,
    parameter int OUTPUT_LINE_STRIDE = 2048
) (
    input  logic              clk_i,
    input  logic              resetn_i,
    input  logic              start_i,
    input  logic [ROW_W-1:0]  cfg_rows_i,
    input  logic [STEP_W-1:0] cfg_kernel_steps_i,
    input  logic [STEP_W-1:0] cfg_channel_steps_i,
    input  logic [ADDR_W-1:0] cfg_kstep_bytes_i,
    input  logic              cfg_strided_i,
    input  logic              line_release_i,
    output logic              cmd_valid_o,
    input  logic              cmd_ready_i,
    output logic [ROW_W-1:0]  cmd_row_o,
    output logic [STEP_W-1:0] cmd_kernel_step_o,
    output logic [STEP_W-1:0] cmd_channel_step_o,
    output logic [ADDR_W-1:0] cmd_out_addr_o,
    output logic              cmd_last_channel_o,
    output logic              cmd_last_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              credit_err_o
);

    localparam int CW = $clog2(NUM_OUTPUT_LINES + 1);
    localparam int LW = (NUM_OUTPUT_LINES > 1) ? $clog2(NUM_OUTPUT_LINES) : 1;

    localparam logic [CW-1:0]     CREDIT_FULL = CW'(NUM_OUTPUT_LINES);
    localparam logic [LW-1:0]     LINE_LAST   = LW'(NUM_OUTPUT_LINES - 1);
    localparam logic [ADDR_W-1:0] LINE_BASE   = ADDR_W'(OUTPUT_LINE_BASE);
    localparam logic [ADDR_W-1:0] LINE_STRIDE = ADDR_W'(OUTPUT_LINE_STRIDE);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_LINE = 2'd1,
        S_ISSUE     = 2'd2,
        S_DONE      = 2'd3
    } state_e;

    state_e state_q;

    // Registered command outputs
    logic              cmd_valid_q;
    logic [ROW_W-1:0]  cmd_row_q;
    logic [STEP_W-1:0] cmd_kstep_q;
    logic [STEP_W-1:0] cmd_cstep_q;
    logic [ADDR_W-1:0] cmd_addr_q;
    logic              cmd_last_channel_q;
    logic              cmd_last_q;
    logic              busy_q;
    logic              done_q;

    // Configuration latched on an accepted start
    logic [ROW_W-1:0]  rows_q;
    logic [STEP_W-1:0] ksteps_q;
    logic [STEP_W-1:0] csteps_q;
    logic [ADDR_W-1:0] kstep_bytes_q;

    // Row / line walk
    logic [ROW_W-1:0]  row_q;
    logic [LW-1:0]     line_q;
    logic [ADDR_W-1:0] line_addr_q;

    // Credits
    logic [CW-1:0]     credit_q;
    logic [CW-1:0]     credit_d;
    logic              credit_err_q;
    logic              credit_err_d;

    // Next-command and walk helpers
    logic              stride_two;
    logic              start_accept;
    logic              cfg_zero;
    logic              handshake;
    logic              credit_take;
    logic              chan_last;
    logic              kstep_last;
    logic              row_last;
    logic [ROW_W:0]    row_step;
    logic [ROW_W:0]    row_adv_wide;
    logic [ROW_W-1:0]  row_d;
    logic              line_wrap;
    logic [LW-1:0]     line_d;
    logic [ADDR_W-1:0] line_addr_d;
    logic [STEP_W-1:0] cmd_cstep_d;
    logic [STEP_W-1:0] cmd_kstep_d;
    logic [ADDR_W-1:0] cmd_addr_d;
    logic              cmd_last_channel_d;
    logic              cmd_last_d;

    // -------------------------------------------------------------------------
    // Stride selection
    // -------------------------------------------------------------------------
`ifdef OUTPUT_SEQ_STRIDED_EN
    logic strided_q;

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            strided_q <= 1'b0;
        end else if (start_accept) begin
            strided_q <= cfg_strided_i;
        end
    end

    assign stride_two = strided_q;
`else
    logic unused_cfg_strided;
    assign unused_cfg_strided = cfg_strided_i;
    assign stride_two         = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Combinational helpers
    // -------------------------------------------------------------------------
    assign start_accept = (state_q == S_IDLE) && start_i;
    assign cfg_zero     = (cfg_rows_i == '0) || (cfg_kernel_steps_i == '0) ||
                          (cfg_channel_steps_i == '0);
    assign handshake    = cmd_valid_q && cmd_ready_i;
    assign credit_take  = (state_q == S_WAIT_LINE) && (credit_q != '0);

    assign chan_last  = (cmd_cstep_q == (csteps_q - STEP_W'(1)));
    assign kstep_last = (cmd_kstep_q == (ksteps_q - STEP_W'(1)));

    // Row arithmetic is one bit wider so a +2 step near the top of the
    // row range cannot wrap and be mistaken for a non-final row.
    assign row_step     = stride_two ? (ROW_W + 1)'(2) : (ROW_W + 1)'(1);
    assign row_adv_wide = {1'b0, row_q} + row_step;
    assign row_last     = (row_adv_wide >= {1'b0, rows_q});
    assign row_d        = row_adv_wide[ROW_W-1:0];

    assign line_wrap   = (line_q == LINE_LAST);
    assign line_d      = line_wrap ? '0 : (line_q + LW'(1));
    assign line_addr_d = line_wrap ? LINE_BASE : (line_addr_q + LINE_STRIDE);

    // Fields of the command that gets loaded next: the first step of the
    // current row when leaving WAIT_LINE, otherwise the successor of the
    // command currently presented. The kernel-step address is accumulated
    // rather than multiplied.
    always_comb begin
        cmd_cstep_d = '0;
        cmd_kstep_d = '0;
        cmd_addr_d  = line_addr_q;
        if (state_q == S_ISSUE) begin
            if (!chan_last) begin
                cmd_cstep_d = cmd_cstep_q + STEP_W'(1);
                cmd_kstep_d = cmd_kstep_q;
                cmd_addr_d  = cmd_addr_q;
            end else begin
                cmd_cstep_d = '0;
                cmd_kstep_d = cmd_kstep_q + STEP_W'(1);
                cmd_addr_d  = cmd_addr_q + kstep_bytes_q;
            end
        end
        cmd_last_channel_d = (cmd_cstep_d == (csteps_q - STEP_W'(1)));
        cmd_last_d         = cmd_last_channel_d &&
                             (cmd_kstep_d == (ksteps_q - STEP_W'(1))) &&
                             row_last;
    end

    // Credit bookkeeping: a take and a release in the same cycle cancel out;
    // a lone release while full is flagged instead of overflowing.
    always_comb begin
        credit_d     = credit_q;
        credit_err_d = credit_err_q;
        if (credit_take && !line_release_i) begin
            credit_d = credit_q - CW'(1);
        end else if (!credit_take && line_release_i) begin
            if (credit_q == CREDIT_FULL) begin
                credit_err_d = 1'b1;
            end else begin
                credit_d = credit_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            credit_q     <= CREDIT_FULL;
            credit_err_q <= 1'b0;
        end else begin
            credit_q     <= credit_d;
            credit_err_q <= credit_err_d;
        end
    end

    // -------------------------------------------------------------------------
    // Sequencer FSM with registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q            <= S_IDLE;
            cmd_valid_q        <= 1'b0;
            cmd_row_q          <= '0;
            cmd_kstep_q        <= '0;
            cmd_cstep_q        <= '0;
            cmd_addr_q         <= '0;
            cmd_last_channel_q <= 1'b0;
            cmd_last_q         <= 1'b0;
            busy_q             <= 1'b0;
            done_q             <= 1'b0;
            rows_q             <= '0;
            ksteps_q           <= '0;
            csteps_q           <= '0;
            kstep_bytes_q      <= '0;
            row_q              <= '0;
            line_q             <= '0;
            line_addr_q        <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        rows_q        <= cfg_rows_i;
                        ksteps_q      <= cfg_kernel_steps_i;
                        csteps_q      <= cfg_channel_steps_i;
                        kstep_bytes_q <= cfg_kstep_bytes_i;
                        row_q         <= '0;
                        line_q        <= '0;
                        line_addr_q   <= LINE_BASE;
                        busy_q        <= 1'b1;
                        if (cfg_zero) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_WAIT_LINE;
                        end
                    end
                end

                S_WAIT_LINE: begin
                    if (credit_take) begin
                        state_q            <= S_ISSUE;
                        cmd_valid_q        <= 1'b1;
                        cmd_row_q          <= row_q;
                        cmd_kstep_q        <= cmd_kstep_d;
                        cmd_cstep_q        <= cmd_cstep_d;
                        cmd_addr_q         <= cmd_addr_d;
                        cmd_last_channel_q <= cmd_last_channel_d;
                        cmd_last_q         <= cmd_last_d;
                    end
                end

                S_ISSUE: begin
                    if (handshake) begin
                        if (!(chan_last && kstep_last)) begin
                            cmd_kstep_q        <= cmd_kstep_d;
                            cmd_cstep_q        <= cmd_cstep_d;
                            cmd_addr_q         <= cmd_addr_d;
                            cmd_last_channel_q <= cmd_last_channel_d;
                            cmd_last_q         <= cmd_last_d;
                        end else begin
                            // Row finished: drop valid and clear the flags so
                            // they never linger outside a valid command.
                            cmd_valid_q        <= 1'b0;
                            cmd_last_channel_q <= 1'b0;
                            cmd_last_q         <= 1'b0;
                            if (row_last) begin
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                            end else begin
                                state_q     <= S_WAIT_LINE;
                                row_q       <= row_d;
                                line_q      <= line_d;
                                line_addr_q <= line_addr_d;
                            end
                        end
                    end
                end

                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_valid_o        = cmd_valid_q;
    assign cmd_row_o          = cmd_row_q;
    assign cmd_kernel_step_o  = cmd_kstep_q;
    assign cmd_channel_step_o = cmd_cstep_q;
    assign cmd_out_addr_o     = cmd_addr_q;
    assign cmd_last_channel_o = cmd_last_channel_q;
    assign cmd_last_o         = cmd_last_q;
    assign busy_o             = busy_q;
    assign done_o             = done_q;
    assign credit_err_o       = credit_err_q;

endmodule

// File: tb/tb_output_line_step_sequencer.sv
// -----------------------------------------------------------------------------
// tb_output_line_step_sequencer
//
// Directed bench for output_line_step_sequencer. Each scenario task drives a
// layer, collects the accepted commands and compares them against
// hand-computed expectations. Cycle index j counts samples after the edge
// that accepted start (j = 0 is the cycle right after that edge).
// -----------------------------------------------------------------------------
module tb_output_line_step_sequencer;

    logic        clk;
    logic        resetn;
    logic        start;
    logic [11:0] cfg_rows;
    logic [15:0] cfg_kernel_steps;
    logic [15:0] cfg_channel_steps;
    logic [31:0] cfg_kstep_bytes;
    logic        cfg_strided;
    logic        line_release;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [11:0] cmd_row;
    logic [15:0] cmd_kernel_step;
    logic [15:0] cmd_channel_step;
    logic [31:0] cmd_out_addr;
    logic        cmd_last_channel;
    logic        cmd_last;
    logic        busy;
    logic        done;
    logic        credit_err;

    int vectors;
    int miscompares;

    // Collected commands of the last run_layer call
    int          got_n;
    int          got_row  [0:63];
    int          got_k    [0:63];
    int          got_c    [0:63];
    logic [31:0] got_addr [0:63];
    logic        got_lc   [0:63];
    logic        got_last [0:63];
    int          got_j    [0:63];
    int          done_j;
    logic        busy_at_done;
    logic        busy_after;
    int          stall_viol;

    output_line_step_sequencer dut (
        .clk_i              (clk),
        .resetn_i           (resetn),
        .start_i            (start),
        .cfg_rows_i         (cfg_rows),
        .cfg_kernel_steps_i (cfg_kernel_steps),
        .cfg_channel_steps_i(cfg_channel_steps),
        .cfg_kstep_bytes_i  (cfg_kstep_bytes),
        .cfg_strided_i      (cfg_strided),
        .line_release_i     (line_release),
        .cmd_valid_o        (cmd_valid),
        .cmd_ready_i        (cmd_ready),
        .cmd_row_o          (cmd_row),
        .cmd_kernel_step_o  (cmd_kernel_step),
        .cmd_channel_step_o (cmd_channel_step),
        .cmd_out_addr_o     (cmd_out_addr),
        .cmd_last_channel_o (cmd_last_channel),
        .cmd_last_o         (cmd_last),
        .busy_o             (busy),
        .done_o             (done),
        .credit_err_o       (credit_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn       = 1'b0;
        start        = 1'b0;
        line_release = 1'b0;
        cmd_ready    = 1'b1;
        cfg_strided  = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
        tick();
    endtask

    task automatic set_cfg(input int rows, input int ks, input int cs, input int kb);
        cfg_rows          = 12'(rows);
        cfg_kernel_steps  = 16'(ks);
        cfg_channel_steps = 16'(cs);
        cfg_kstep_bytes   = 32'(kb);
    endtask

    // Pulses start, then runs up to max_cycles sample points.
    // ready_mode 0: ready held high, 1: random ready.
    // rel_kstep >= 0: return a line credit on each row-ending handshake
    //   (last channel step with that kernel step).
    // release_at / start_at: cycle index of a one-shot release / stray start
    //   (the stray start also perturbs the config inputs).
    task automatic run_layer(input int max_cycles, input int ready_mode,
                             input int rel_kstep, input int release_at,
                             input int start_at);
        logic        prev_hold;
        logic        hs;
        logic [11:0] p_row;
        logic [15:0] p_k;
        logic [15:0] p_c;
        logic [31:0] p_addr;
        logic        p_lc;
        logic        p_last;
        got_n        = 0;
        done_j       = -1;
        stall_viol   = 0;
        busy_at_done = 1'b0;
        busy_after   = 1'b1;
        prev_hold    = 1'b0;
        p_row = '0; p_k = '0; p_c = '0; p_addr = '0; p_lc = 1'b0; p_last = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 0; j < max_cycles; j++) begin
            cmd_ready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            if (j == start_at) begin
                start             = 1'b1;
                cfg_rows          = 12'd1;
                cfg_channel_steps = 16'd1;
            end else begin
                start = 1'b0;
            end
            if (prev_hold) begin
                if (!cmd_valid || cmd_row !== p_row || cmd_kernel_step !== p_k ||
                    cmd_channel_step !== p_c || cmd_out_addr !== p_addr ||
                    cmd_last_channel !== p_lc || cmd_last !== p_last)
                    stall_viol++;
            end
            hs = cmd_valid && cmd_ready;
            line_release = (j == release_at) ||
                           (rel_kstep >= 0 && hs && cmd_last_channel &&
                            int'(cmd_kernel_step) == rel_kstep);
            if (hs && got_n < 64) begin
                got_row[got_n]  = int'(cmd_row);
                got_k[got_n]    = int'(cmd_kernel_step);
                got_c[got_n]    = int'(cmd_channel_step);
                got_addr[got_n] = cmd_out_addr;
                got_lc[got_n]   = cmd_last_channel;
                got_last[got_n] = cmd_last;
                got_j[got_n]    = j;
                got_n++;
            end
            prev_hold = cmd_valid && !cmd_ready;
            p_row = cmd_row; p_k = cmd_kernel_step; p_c = cmd_channel_step;
            p_addr = cmd_out_addr; p_lc = cmd_last_channel; p_last = cmd_last;
            if (done) begin
                done_j       = j;
                busy_at_done = busy;
                tick();
                busy_after   = busy;
                break;
            end
            tick();
        end
        start        = 1'b0;
        line_release = 1'b0;
        cmd_ready    = 1'b1;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset();
        resetn = 1'b0; start = 1'b0; line_release = 1'b0; cmd_ready = 1'b1;
        cfg_strided = 1'b0;
        set_cfg(0, 0, 0, 0);
        #1;
        vectors++;
        if ({cmd_valid, busy, done, credit_err, cmd_last, cmd_last_channel} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got %b expected 000000",
                     {cmd_valid, busy, done, credit_err, cmd_last, cmd_last_channel});
        end
        vectors++;
        if ({cmd_row, cmd_kernel_step, cmd_channel_step, cmd_out_addr} !== 76'b0) begin
            miscompares++;
            $display("FAIL reset_fields: got row=%0d k=%0d c=%0d addr=%0d expected all 0",
                     cmd_row, cmd_kernel_step, cmd_channel_step, cmd_out_addr);
        end
        tick();
        resetn = 1'b1;
        tick();
        tick();
        vectors++;
        if ({busy, cmd_valid, done} !== 3'b0) begin
            miscompares++;
            $display("FAIL reset_idle: got busy/valid/done=%b expected 000", {busy, cmd_valid, done});
        end
        $display("test_reset: done");
    endtask

    // -------------------------------------------------------------------------
    task automatic test_basic();
        int exp_addr [0:11] = '{6144, 6144, 6144, 6208, 6208, 6208,
                                8192, 8192, 8192, 8256, 8256, 8256};
        int exp_j    [0:11] = '{1, 2, 3, 4, 5, 6, 8, 9, 10, 11, 12, 13};
        do_reset();
        set_cfg(2, 2, 3, 64);
        run_layer(60, 0, -1, -1, -1);
        vectors++;
        if (got_n != 12) begin
            miscompares++;
            $display("FAIL basic_count: got %0d expected 12", got_n);
        end
        for (int i = 0; i < 12 && i < got_n; i++) begin
            vectors++;
            if (got_addr[i] !== 32'(exp_addr[i]) || got_j[i] != exp_j[i] ||
                got_row[i] != i / 6 || got_k[i] != (i / 3) % 2 || got_c[i] != i % 3 ||
                got_lc[i] !== (i % 3 == 2) || got_last[i] !== (i == 11)) begin
                miscompares++;
                $display("FAIL basic_cmd[%0d]: got addr=%0d j=%0d row=%0d k=%0d c=%0d lc=%b last=%b expected addr=%0d j=%0d row=%0d k=%0d c=%0d lc=%b last=%b",
                         i, got_addr[i], got_j[i], got_row[i], got_k[i], got_c[i], got_lc[i], got_last[i],
                         exp_addr[i], exp_j[i], i / 6, (i / 3) % 2, i % 3, (i % 3 == 2), (i == 11));
            end
            $display("basic cmd %0d: j=%0d row=%0d k=%0d c=%0d addr=%0d lc=%b last=%b",
                     i, got_j[i], got_row[i], got_k[i], got_c[i], got_addr[i], got_lc[i], got_last[i]);
        end
        vectors++;
        if (done_j != 14 || busy_at_done !== 1'b1 || busy_after !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_done: got done_j=%0d busy=%b busy_next=%b expected 14 1 0",
                     done_j, busy_at_done, busy_after);
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_line_wrap();
        int exp_addr [0:3] = '{6144, 8192, 10240, 6144};
        int exp_j    [0:3] = '{1, 3, 5, 12};
        do_reset();
        set_cfg(4, 1, 1, 64);
        run_layer(60, 0, -1, 10, -1);
        vectors++;
        if (got_n != 4) begin
            miscompares++;
            $display("FAIL wrap_count: got %0d expected 4", got_n);
        end
        for (int i = 0; i < 4 && i < got_n; i++) begin
            vectors++;
            if (got_addr[i] !== 32'(exp_addr[i]) || got_j[i] != exp_j[i] ||
                got_row[i] != i || got_last[i] !== (i == 3)) begin
                miscompares++;
                $display("FAIL wrap_cmd[%0d]: got addr=%0d j=%0d row=%0d last=%b expected addr=%0d j=%0d row=%0d last=%b",
                         i, got_addr[i], got_j[i], got_row[i], got_last[i],
                         exp_addr[i], exp_j[i], i, (i == 3));
            end
            $display("wrap cmd %0d: j=%0d row=%0d addr=%0d", i, got_j[i], got_row[i], got_addr[i]);
        end
        vectors++;
        if (done_j != 13) begin
            miscompares++;
            $display("FAIL wrap_done: got done_j=%0d expected 13", done_j);
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_strided();
        int exp_n;
        int exp_row  [0:4];
        int exp_addr [0:4];
        do_reset();
        set_cfg(5, 1, 1, 64);
        cfg_strided = 1'b1;
`ifdef OUTPUT_SEQ_STRIDED_EN
        exp_n    = 3;
        exp_row  = '{0, 2, 4, 0, 0};
        exp_addr = '{6144, 8192, 10240, 0, 0};
`else
        exp_n    = 5;
        exp_row  = '{0, 1, 2, 3, 4};
        exp_addr = '{6144, 8192, 10240, 6144, 8192};
`endif
        run_layer(80, 0, 0, -1, -1);
        cfg_strided = 1'b0;
        vectors++;
        if (got_n != exp_n) begin
            miscompares++;
            $display("FAIL strided_count: got %0d expected %0d", got_n, exp_n);
        end
        for (int i = 0; i < exp_n && i < got_n; i++) begin
            vectors++;
            if (got_row[i] != exp_row[i] || got_addr[i] !== 32'(exp_addr[i]) ||
                got_last[i] !== (i == exp_n - 1)) begin
                miscompares++;
                $display("FAIL strided_cmd[%0d]: got row=%0d addr=%0d last=%b expected row=%0d addr=%0d last=%b",
                         i, got_row[i], got_addr[i], got_last[i], exp_row[i], exp_addr[i], (i == exp_n - 1));
            end
            $display("strided cmd %0d: row=%0d addr=%0d", i, got_row[i], got_addr[i]);
        end
        vectors++;
        if (done_j < 0) begin
            miscompares++;
            $display("FAIL strided_done: got done_j=%0d expected a done pulse", done_j);
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_backpressure();
        int n;
        int e_addr;
        do_reset();
        set_cfg(3, 2, 2, 100);
        run_layer(400, 1, 1, -1, -1);
        vectors++;
        if (got_n != 12) begin
            miscompares++;
            $display("FAIL bp_count: got %0d expected 12", got_n);
        end
        vectors++;
        if (stall_viol != 0) begin
            miscompares++;
            $display("FAIL bp_stable: got %0d unstable stall cycles expected 0", stall_viol);
        end
        n = 0;
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 2; k++) begin
                for (int c = 0; c < 2; c++) begin
                    e_addr = 6144 + r * 2048 + k * 100;
                    if (n < got_n) begin
                        vectors++;
                        if (got_row[n] != r || got_k[n] != k || got_c[n] != c ||
                            got_addr[n] !== 32'(e_addr)) begin
                            miscompares++;
                            $display("FAIL bp_cmd[%0d]: got row=%0d k=%0d c=%0d addr=%0d expected row=%0d k=%0d c=%0d addr=%0d",
                                     n, got_row[n], got_k[n], got_c[n], got_addr[n], r, k, c, e_addr);
                        end
                        $display("bp cmd %0d: j=%0d row=%0d k=%0d c=%0d addr=%0d",
                                 n, got_j[n], got_row[n], got_k[n], got_c[n], got_addr[n]);
                    end
                    n++;
                end
            end
        end
        vectors++;
        if (done_j < 0) begin
            miscompares++;
            $display("FAIL bp_done: got done_j=%0d expected a done pulse", done_j);
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_zero_count();
        do_reset();
        set_cfg(2, 2, 0, 64);
        run_layer(10, 0, -1, -1, -1);
        vectors++;
        if (done_j != 0 || busy_at_done !== 1'b1 || busy_after !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_done: got done_j=%0d busy=%b busy_next=%b expected 0 1 0",
                     done_j, busy_at_done, busy_after);
        end
        tick();
        tick();
        vectors++;
        if (got_n != 0 || cmd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_nocmd: got %0d commands valid=%b expected 0 0", got_n, cmd_valid);
        end
        $display("zero_count: done_j=%0d commands=%0d", done_j, got_n);
    endtask

    // -------------------------------------------------------------------------
    task automatic test_start_while_busy();
        do_reset();
        set_cfg(2, 2, 3, 64);
        run_layer(60, 0, -1, -1, 5);
        vectors++;
        if (got_n != 12 || done_j != 14) begin
            miscompares++;
            $display("FAIL busy_start: got %0d commands done_j=%0d expected 12 14", got_n, done_j);
        end
        vectors++;
        if (got_n >= 12 && got_addr[11] !== 32'd8256) begin
            miscompares++;
            $display("FAIL busy_start_addr: got %0d expected 8256", got_addr[11]);
        end
        tick();
        tick();
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_start_idle: got busy=%b expected 0", busy);
        end
        $display("start_while_busy: commands=%0d done_j=%0d", got_n, done_j);
    endtask

    // -------------------------------------------------------------------------
    task automatic test_credit_err();
        do_reset();
        vectors++;
        if (credit_err !== 1'b0) begin
            miscompares++;
            $display("FAIL credit_err_init: got %b expected 0", credit_err);
        end
        line_release = 1'b1;
        tick();
        line_release = 1'b0;
        vectors++;
        if (credit_err !== 1'b1) begin
            miscompares++;
            $display("FAIL credit_err_set: got %b expected 1", credit_err);
        end
        // Credits must still be 3: exactly three rows issue, then a stall.
        set_cfg(4, 1, 1, 64);
        run_layer(30, 0, -1, -1, -1);
        vectors++;
        if (got_n != 3 || done_j != -1) begin
            miscompares++;
            $display("FAIL credit_full_count: got %0d commands done_j=%0d expected 3 -1", got_n, done_j);
        end
        vectors++;
        if (credit_err !== 1'b1) begin
            miscompares++;
            $display("FAIL credit_err_sticky: got %b expected 1", credit_err);
        end
        $display("credit_err: commands=%0d err=%b", got_n, credit_err);
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset_mid();
        do_reset();
        set_cfg(2, 2, 3, 64);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        vectors++;
        if (cmd_valid !== 1'b1 || cmd_out_addr !== 32'd6208) begin
            miscompares++;
            $display("FAIL mid_progress: got valid=%b addr=%0d expected 1 6208", cmd_valid, cmd_out_addr);
        end
        resetn = 1'b0;
        #1;
        vectors++;
        if ({cmd_valid, busy, done, cmd_last, cmd_last_channel} !== 5'b0 ||
            {cmd_row, cmd_kernel_step, cmd_channel_step, cmd_out_addr} !== 76'b0) begin
            miscompares++;
            $display("FAIL mid_reset: got valid=%b busy=%b row=%0d k=%0d c=%0d addr=%0d expected all 0",
                     cmd_valid, busy, cmd_row, cmd_kernel_step, cmd_channel_step, cmd_out_addr);
        end
        tick();
        resetn = 1'b1;
        tick();
        run_layer(60, 0, -1, -1, -1);
        vectors++;
        if (got_n != 12 || got_j[0] != 1 || got_row[0] != 0 || got_addr[0] !== 32'd6144) begin
            miscompares++;
            $display("FAIL mid_restart: got n=%0d j=%0d row=%0d addr=%0d expected 12 1 0 6144",
                     got_n, got_j[0], got_row[0], got_addr[0]);
        end
        $display("reset_mid: restart commands=%0d first addr=%0d", got_n, got_addr[0]);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_basic();
        test_line_wrap();
        test_strided();
        test_backpressure();
        test_zero_count();
        test_start_while_busy();
        test_credit_err();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/output_line_step_sequencer.md
# output_line_step_sequencer

Runtime-configurable step sequencer for a dense/conv layer. It walks output rows × kernel steps × channel steps and issues one command per step over a valid/ready interface. Each command carries the output-line AXI write address. Output lines are rotated through `NUM_OUTPUT_LINES` credit-guarded line buffers, generalising the fixed three-line scheme. The block sits between the layer control registers and the PE-array/output-writer datapath.

## Interface
Parameters:
- `ADDR_W`, 32, AXI address width (matches `AXI_BUS_ADDRESS_WIDTH`)
- `STEP_W`, 16, width of kernel/channel step counters
- `ROW_W`, 12, width of the row counter
- `NUM_OUTPUT_LINES`, 3, number of rotating output line buffers (≥1)
- `OUTPUT_LINE_BASE`, 6144, byte address of line 0
- `OUTPUT_LINE_STRIDE`, 2048, byte distance between consecutive lines

Ports:
- `clk`  in  1  single clock, rising edge
- `resetn`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle layer start; honoured only in IDLE
- `cfg_rows`  in  ROW_W  input/output rows
- `cfg_kernel_steps`  in  STEP_W  kernel steps per row
- `cfg_channel_steps`  in  STEP_W  channel steps per kernel step
- `cfg_kstep_bytes`  in  ADDR_W  address increment per kernel step
- `cfg_strided`  in  1  stride-2 row mode
- `line_release`  in  1  consumer frees one output line (credit return)
- `cmd_valid`  out  1  command valid
- `cmd_ready`  in  1  downstream accepts the command
- `cmd_row`  out  ROW_W  input row index
- `cmd_kernel_step`  out  STEP_W  kernel step
- `cmd_channel_step`  out  STEP_W  channel step
- `cmd_out_addr`  out  ADDR_W  output write address
- `cmd_last_channel`  out  1  channel_step == cfg_channel_steps−1 (writeback step)
- `cmd_last`  out  1  final command of the layer
- `busy`  out  1  not in IDLE
- `done`  out  1  one-cycle completion pulse
- `credit_err`  out  1  sticky: release while credits full

## Operation
- Config is latched on the accepted `start`. Later config changes have no effect until the next start.
- FSM states:
  - IDLE: `start` → WAIT_LINE. If any latched count is 0 → DONE instead.
  - WAIT_LINE: credits > 0 → consume one credit, go to ISSUE; otherwise stay.
  - ISSUE: on handshake (`cmd_valid & cmd_ready`), advance the channel step, then the kernel step. At the end of a row → WAIT_LINE; at the end of the last row → DONE.
  - DONE: assert `done` for one cycle, then go to IDLE.
- Loop order (innermost first): channel step, kernel step, row.
- Row advance: +1, or +2 when strided. Rows emitted = cfg_rows, or ceil(cfg_rows/2) when strided.
- Line index:
  - starts at 0 and increments once per emitted row;
  - wraps from NUM_OUTPUT_LINES−1 to 0.
- `cmd_out_addr` = OUTPUT_LINE_BASE + line·OUTPUT_LINE_STRIDE + kernel_step·cfg_kstep_bytes, modulo 2^ADDR_W.
- Credits:
  - counter width clog2(NUM_OUTPUT_LINES+1); reset value NUM_OUTPUT_LINES; not reset by `start`.
  - consume and release in the same cycle → count unchanged.
  - release at full → count unchanged, `credit_err` set.
  - `credit_err` clears only on reset.
- `start` is ignored while `busy`.

## Timing
- Reset values: `cmd_valid`, `busy`, `done`, `credit_err`, `cmd_last`, `cmd_last_channel` = 0; all command fields = 0; FSM = IDLE; line = 0.
- `start` sampled at edge t → `busy` = 1 from t+1.
- First `cmd_valid` appears at t+2 when credits are available.
- Within a row, with `cmd_ready` held high: one command per cycle, including across kernel-step boundaries.
- Each row boundary inserts exactly one bubble cycle (WAIT_LINE), plus any cycles stalled on zero credits.
- While `cmd_valid` is high and `cmd_ready` is low, all `cmd_*` outputs hold stable.
- Final handshake at edge n → `done` = 1 and `busy` = 1 in cycle n+1 → `busy` = 0 from n+2.
- Zero-count start at t → `done` at t+1, no commands issued.
- `resetn` deasserted (low) mid-layer: all state returns to reset values asynchronously; any in-flight command is dropped.

## Configuration
- `OUTPUT_SEQ_STRIDED_EN`
  - Defined: `cfg_strided` is honoured as described.
  - Undefined: `cfg_strided` is ignored and treated as 0; the stride logic is not synthesised.

## Test plan
- Basic sequence: rows=2, ksteps=2, csteps=3, kstep_bytes=64, ready always high.
  - Exactly 12 commands; one bubble between rows.
  - Addresses 6144×3, 6208×3, 8192×3, 8256×3.
  - `cmd_last_channel` on every third command; `cmd_last` only on the 12th; `done` one cycle later.
- Line wrap with credit stall: rows=4, ksteps=1, csteps=1, no `line_release`.
  - Addresses 6144, 8192, 10240, then stall in WAIT_LINE.
  - One `line_release` → the fourth command issues at 6144.
- Strided mode (macro defined): rows=5, `cfg_strided`=1.
  - `cmd_row` sequence 0, 2, 4; lines 0, 1, 2.
  - With the macro undefined, the same config gives rows 0–4.
- Backpressure: randomly toggled `cmd_ready`.
  - Fields stable while stalled; no command is lost or duplicated (compare against a scoreboard).
- Boundary cases:
  - `cfg_channel_steps`=0 → `done` at t+1, `cmd_valid` never asserted.
  - `start` pulsed while busy → ignored.
  - `line_release` at full credits → `credit_err`=1 and credits remain 3.
- Reset mid-layer: pulse `resetn` low after 5 handshakes.
  - All outputs return to 0 immediately; a fresh start restarts from row 0 at address 6144.
